fp_alu: RTL and testbench

- Registered single-precision (IEEE-754 binary32) floating-point ALU.
- Takes two 32-bit operands and a 2-bit opcode, computes add, subtract or multiply, and registers the result on the rising clock edge.
- Used as a datapath arithmetic unit.
- All combinational float logic sits between the input ports and one output register.

---
 rtl/fp32_pkg.sv | 47 ++++
 rtl/fp32_round_pack.sv | 31 +++
 rtl/fp_alu.sv | 157 +++++++++++++++
 tb/tb_fp_alu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, opcode encoding and the unpacked-operand view
// used by the fp_alu datapaths.
package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // mant carries the hidden bit; subnormals are reported as zero.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp_unpacked_t;

    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.mant    = {1'b1, x[22:0]};
        u.is_zero = (x[30:23] == 8'd0);
        u.is_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
        u.is_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
        return u;
    endfunction

    // Leading-zero count of a 27-bit value; 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even, overflow-to-infinity and flush-to-zero, then pack
// a normalised significand (hidden bit at [26], G/R/S at [2:0]) into binary32.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp_unb,
    input  logic [26:0]        sig,
    output logic [31:0]        result
);

    logic               round_up;
    logic [24:0]        mant_rnd;
    logic signed [10:0] exp_b;
    logic [22:0]        frac;

    always_comb begin
        round_up = sig[2] & (sig[1] | sig[0] | sig[3]);
        mant_rnd = {1'b0, sig[26:3]} + {24'd0, round_up};
        exp_b    = {exp_unb[9], exp_unb} + 11'(EXP_BIAS) + {10'd0, mant_rnd[24]};
        frac     = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
        if (exp_b >= 11'sd255) begin
            result = {sign, EXP_MAX, 23'd0};
        end else if (exp_b <= 11'sd0) begin
            result = {sign, 31'd0};
        end else begin
            result = {sign, exp_b[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_alu.sv
// Registered binary32 add/sub/mul unit: combinational float datapath feeding
// a single output register, one result per clock.
module fp_alu
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  OpCode,
    output logic [31:0] O
);

    op_e                op;
    fp_unpacked_t       ua;
    fp_unpacked_t       ub;
    logic               b_sign_eff;
    logic               a_bigger;
    logic               eff_sub;
    logic               big_sign;
    logic [7:0]         big_exp;
    logic [7:0]         small_exp;
    logic [23:0]        big_mant;
    logic [23:0]        small_mant;
    logic [7:0]         exp_diff;
    logic [26:0]        small_ext;
    logic [26:0]        lost;
    logic [26:0]        aligned;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic [26:0]        add_sig;
    logic signed [9:0]  add_exp;
    logic [47:0]        prod;
    logic [26:0]        mul_sig;
    logic signed [9:0]  mul_exp;
    logic               mul_sign;
    logic               rp_sign;
    logic signed [9:0]  rp_exp;
    logic [26:0]        rp_sig;
    logic [31:0]        rp_out;
    logic [31:0]        o_d;
    logic [31:0]        o_q;

    always_comb begin
        op         = op_e'(OpCode);
        ua         = fp_unpack(A);
        ub         = fp_unpack(B);
        b_sign_eff = ub.sign ^ (op == OP_SUB);

        a_bigger   = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
        big_sign   = a_bigger ? ua.sign : b_sign_eff;
        big_exp    = a_bigger ? ua.exp  : ub.exp;
        big_mant   = a_bigger ? ua.mant : ub.mant;
        small_exp  = a_bigger ? ub.exp  : ua.exp;
        small_mant = a_bigger ? ub.mant : ua.mant;
        eff_sub    = ua.sign ^ b_sign_eff;
        exp_diff   = big_exp - small_exp;
        small_ext  = {small_mant, 3'b000};
        lost       = small_ext & ~(27'h7FF_FFFF << exp_diff);

        // Past 25 positions nothing of the smaller operand reaches G or R.
        if (exp_diff >= 8'd26) begin
            aligned = 27'd1;
        end else begin
            aligned = (small_ext >> exp_diff) | {26'd0, |lost};
        end

        if (eff_sub) begin
            sum = {1'b0, big_mant, 3'b000} - {1'b0, aligned};
        end else begin
            sum = {1'b0, big_mant, 3'b000} + {1'b0, aligned};
        end

        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            add_sig = {sum[27:2], sum[1] | sum[0]};
            add_exp = $signed({2'b00, big_exp}) - 10'sd126;
        end else begin
            add_sig = sum[26:0] << lz;
            add_exp = $signed({2'b00, big_exp}) - 10'sd127 - $signed({5'd0, lz});
        end

        prod     = 48'(ua.mant) * 48'(ub.mant);
        mul_sign = ua.sign ^ ub.sign;
        if (prod[47]) begin
            mul_sig = {prod[47:22], |prod[21:0]};
            mul_exp = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd253;
        end else begin
            mul_sig = {prod[46:21], |prod[20:0]};
            mul_exp = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd254;
        end

        rp_sign = (op == OP_MUL) ? mul_sign : big_sign;
        rp_exp  = (op == OP_MUL) ? mul_exp  : add_exp;
        rp_sig  = (op == OP_MUL) ? mul_sig  : add_sig;
    end

    fp32_round_pack u_round_pack (
        .sign    (rp_sign),
        .exp_unb (rp_exp),
        .sig     (rp_sig),
        .result  (rp_out)
    );

    // Special operands override the numeric path.
    always_comb begin
        o_d = 32'd0;
        case (op)
            OP_ADD, OP_SUB: begin
                if (ua.is_nan || ub.is_nan) begin
                    o_d = QNAN;
                end else if (ua.is_inf && ub.is_inf) begin
                    o_d = (ua.sign != b_sign_eff) ? QNAN : {ua.sign, EXP_MAX, 23'd0};
                end else if (ua.is_inf) begin
                    o_d = {ua.sign, EXP_MAX, 23'd0};
                end else if (ub.is_inf) begin
                    o_d = {b_sign_eff, EXP_MAX, 23'd0};
                end else if (ua.is_zero && ub.is_zero) begin
                    o_d = {ua.sign & b_sign_eff, 31'd0};
                end else if (ub.is_zero) begin
                    o_d = A;
                end else if (ua.is_zero) begin
                    o_d = {b_sign_eff, B[30:0]};
                end else if (sum == 28'd0) begin
                    o_d = 32'd0;
                end else begin
                    o_d = rp_out;
                end
            end
            OP_MUL: begin
                if (ua.is_nan || ub.is_nan) begin
                    o_d = QNAN;
                end else if ((ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
                    o_d = QNAN;
                end else if (ua.is_inf || ub.is_inf) begin
                    o_d = {mul_sign, EXP_MAX, 23'd0};
                end else if (ua.is_zero || ub.is_zero) begin
                    o_d = {mul_sign, 31'd0};
                end else begin
                    o_d = rp_out;
                end
            end
            default: o_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= 32'd0;
        end else begin
            o_q <= o_d;
        end
    end

    assign O = o_q;

endmodule

// File: tb/tb_fp_alu.sv
// Directed-vector bench for fp_alu: table of hand-computed results driven
// back to back, a shuffled replay, and a mid-cycle reset sequence.
module tb_fp_alu;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  OpCode;
    logic [31:0] O;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    fp_alu dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .OpCode (OpCode),
        .O      (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(input string n, input logic [1:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] r);
        vec_t v;
        v.name = n;
        v.op   = op;
        v.a    = a;
        v.b    = b;
        v.res  = r;
        vecs.push_back(v);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: O=%h expected %h", n, act, req);
        end
    endtask

    task automatic compare_front();
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, O, e);
    endtask

    // Each negedge first checks the result of the previous vector, then drives the next.
    task automatic run_vec(input int idx);
        @(negedge clk);
        if (exp_q.size() > 0) compare_front();
        A      = vecs[idx].a;
        B      = vecs[idx].b;
        OpCode = vecs[idx].op;
        exp_q.push_back(vecs[idx].res);
        name_q.push_back(vecs[idx].name);
    endtask

    task automatic drain();
        @(negedge clk);
        while (exp_q.size() > 0) compare_front();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        A      = 32'd0;
        B      = 32'd0;
        OpCode = 2'b00;

        add_vec("add_normal",    2'b00, 32'h49C66D48, 32'h4719CFA7, 32'h49CB3BC5);
        add_vec("add_mixed1",    2'b00, 32'h61FAE82A, 32'hDF4357DE, 32'h61F4CD6B);
        add_vec("add_mixed2",    2'b00, 32'h8C424C2F, 32'h054382E4, 32'h8C424921);
        add_vec("gap_ab",        2'b00, 32'h6F88637F, 32'h05952E31, 32'h6F88637F);
        add_vec("gap_ba",        2'b00, 32'h05952E31, 32'h6F88637F, 32'h6F88637F);
        add_vec("sub_3_2",       2'b01, 32'h40400000, 32'h40000000, 32'h3F800000);
        add_vec("mul_3_2",       2'b10, 32'h40400000, 32'h40000000, 32'h40C00000);
        add_vec("cancel",        2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000);
        add_vec("add_ovf",       2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        add_vec("nan_in",        2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
        add_vec("inf_x_0",       2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000);
        add_vec("reserved",      2'b11, 32'h40400000, 32'h40000000, 32'h00000000);
        add_vec("inf_m_inf",     2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000);
        add_vec("ninf_p_fin",    2'b00, 32'hFF800000, 32'h3F800000, 32'hFF800000);
        add_vec("n0_p_n0",       2'b00, 32'h80000000, 32'h80000000, 32'h80000000);
        add_vec("n0_m_p0",       2'b01, 32'h80000000, 32'h00000000, 32'h80000000);
        add_vec("p0_p_n0",       2'b00, 32'h00000000, 32'h80000000, 32'h00000000);
        add_vec("tiny_p0",       2'b00, 32'h00800000, 32'h00000000, 32'h00800000);
        add_vec("zero_m_one",    2'b01, 32'h00000000, 32'h3F800000, 32'hBF800000);
        add_vec("subnorm_in",    2'b00, 32'h00000001, 32'h00000000, 32'h00000000);
        add_vec("mul_neg",       2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        add_vec("mul_ovf",       2'b10, 32'h7F000000, 32'h7F000000, 32'h7F800000);
        add_vec("mul_uflow",     2'b10, 32'h00800000, 32'h3F000000, 32'h00000000);
        add_vec("rne_tie_even",  2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000);
        add_vec("rne_tie_odd",   2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002);
        add_vec("one_p_one",     2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000);
        add_vec("mul_nan",       2'b10, 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        add_vec("sub_neg_res",   2'b01, 32'h40000000, 32'h40400000, 32'hBF800000);

        #1;
        check("reset_state", O, 32'h00000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);
        drain();

        for (int k = 0; k < 20; k++) run_vec(int'($urandom_range(0, vecs.size() - 1)));
        drain();

        // Mid-cycle reset: clears at once, holds, then first edge after release updates.
        @(negedge clk);
        A      = 32'h40400000;
        B      = 32'h40000000;
        OpCode = 2'b10;
        @(negedge clk);
        check("pre_reset", O, 32'h40C00000);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", O, 32'h00000000);
        @(posedge clk);
        #1;
        check("reset_hold", O, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_no_edge", O, 32'h00000000);
        @(negedge clk);
        check("first_edge_after", O, 32'h40C00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
